dp_ram_clr: RTL

DP_RAM_CLR -- requirements
Module: dp_ram_clr

---
 rtl/dp_ram_clr.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dp_ram_clr.sv
// Dual-port byte-enable RAM with a built-in clear engine that zeroes every word
// after reset or on request, with optional output register and selectable RDW result.
module dp_ram_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     din,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                rd_en;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;

  assign rd_en = (state == IDLE) && re;

  // Reset parks the engine in CLEAR at word 0, so memory is always wiped after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  // In new-data mode a colliding write is merged into the read word before capture.
  always_comb begin
    rd_word = mem[raddr];
    if (RDW_MODE != 0 && we && (waddr == raddr)) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) rd_word[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] out_data;
      logic              out_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_data  <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= rd_valid;
          if (rd_valid) out_data <= rd_data;
        end
      end

      assign dout       = out_data;
      assign dout_valid = out_valid;
    end else begin : g_no_out_reg
      assign dout       = rd_data;
      assign dout_valid = rd_valid;
    end
  endgenerate

endmodule
